disp_frame_capture: RTL and testbench

- Receive-side counterpart of frame_memory_control.
- Accepts a raster video stream (vsync/hsync/de/data), as produced by disp_sync_gen_fsm plus a pixel source.
- Packs 4 consecutive pixels into one MEM_WIDTH word and writes it into FRAMEMEM through the active-low CSN/WEN synchronous port.
- Checks frame geometry, flags errors, and pulses a done strobe after a complete, clean frame.

---
 rtl/state_pkg.sv | 37 +++
 rtl/disp_frame_capture_pixel_packer.sv | 60 ++++++
 rtl/disp_frame_capture.sv | 238 +++++++++++++++++++++++
 tb/tb_disp_frame_capture.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/state_pkg.sv
// ---------------------------------------------------------------------------
// state_pkg
// Shared state encodings and constants for the display pipeline blocks.
//   Vstate_t / Hstate_t : raster generator vertical/horizontal phases
//   cap_state_t         : frame capture FSM (IDLE, CAPTURE)
//   PIX_PER_WORD        : pixels packed per frame-memory word; used by
//                         both frame_memory_control and disp_frame_capture
//   ERR_LINE_LEN/CNT    : bit positions inside the capture error vector
// ---------------------------------------------------------------------------
package state_pkg;

  typedef enum logic [1:0] {
    V_SYNC,
    V_BACK,
    V_ACTIVE,
    V_FRONT
  } Vstate_t;

  typedef enum logic [1:0] {
    H_SYNC,
    H_BACK,
    H_ACTIVE,
    H_FRONT
  } Hstate_t;

  typedef enum logic {
    CAP_IDLE,
    CAP_CAPTURE
  } cap_state_t;

  localparam int PIX_PER_WORD = 4;
  localparam int SLOT_W       = $clog2(PIX_PER_WORD);

  localparam int ERR_LINE_LEN = 0;
  localparam int ERR_LINE_CNT = 1;

endpackage

// File: rtl/disp_frame_capture_pixel_packer.sv
// ---------------------------------------------------------------------------
// pixel_packer
// Collects PIX_PER_WORD consecutive pixels into one memory word. Slot 0 is
// the least significant pixel. The last pixel of a word is not stored: it
// is presented straight from i_data together with the stored slots, so the
// complete word is available on o_word in the same cycle it is accepted.
//   i_clk        : pixel clock
//   rst_n        : asynchronous active-low reset
//   i_valid      : accept i_data into the current slot
//   i_flush      : drop any partial word and return to slot 0
//   i_data       : pixel
//   o_word       : packed word (valid when o_word_valid=1)
//   o_word_valid : this cycle's pixel completes a word
// ---------------------------------------------------------------------------
module pixel_packer
  import state_pkg::*;
#(
  parameter int DATA_WIDTH = 24
) (
  input  logic                               i_clk,
  input  logic                               rst_n,
  input  logic                               i_valid,
  input  logic                               i_flush,
  input  logic [DATA_WIDTH-1:0]              i_data,
  output logic [DATA_WIDTH*PIX_PER_WORD-1:0] o_word,
  output logic                               o_word_valid
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PIX_PER_WORD - 1);

  logic [SLOT_W-1:0]                      r_slot;
  logic [DATA_WIDTH*(PIX_PER_WORD-1)-1:0] r_pack;

  // Flush wins over valid; the two never coincide in normal streams but a
  // flush must always leave the packer at a word boundary.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
      r_pack <= '0;
    end else if (i_flush) begin
      r_slot <= '0;
      r_pack <= '0;
    end else if (i_valid) begin
      if (r_slot == LAST_SLOT) begin
        r_slot <= '0;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
      for (int s = 0; s < PIX_PER_WORD - 1; s++) begin
        if (r_slot == SLOT_W'(s)) begin
          r_pack[s*DATA_WIDTH +: DATA_WIDTH] <= i_data;
        end
      end
    end
  end

  assign o_word       = {i_data, r_pack};
  assign o_word_valid = i_valid & ~i_flush & (r_slot == LAST_SLOT);

endmodule

// File: rtl/disp_frame_capture.sv
// ---------------------------------------------------------------------------
// disp_frame_capture
// Receives a raster video stream, packs PIX_PER_WORD pixels per word and
// writes the words into frame memory through an active-low CSN/WEN port.
// Frame geometry is checked; a one-cycle done strobe marks a clean frame.
//   i_clk        : pixel clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_cap_en     : capture enable, sampled on the vsync rising edge
//   i_vsync      : vertical sync pulse (active high)
//   i_hsync      : horizontal sync pulse (active high)
//   i_de         : data enable; high for active pixels
//   i_data       : pixel data
//   o_fmem_csn   : memory chip select (active low)
//   o_fmem_wen   : memory write enable (active low)
//   o_fmem_addr  : memory word address
//   o_fmem_din   : packed write data
//   o_frame_done : one-cycle pulse after a clean, complete frame
//   o_err        : sticky errors, [0] line length, [1] line count/overflow
//   o_busy       : high while capturing
// ---------------------------------------------------------------------------
module disp_frame_capture
  import state_pkg::*;
#(
  parameter int HRES       = 320,
  parameter int VRES       = 240,
  parameter int DATA_WIDTH = 24,
  parameter int MEM_WIDTH  = DATA_WIDTH * PIX_PER_WORD,
  parameter int ADDR_DEPTH = HRES * VRES / PIX_PER_WORD,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_cap_en,
  input  logic                  i_vsync,
  input  logic                  i_hsync,
  input  logic                  i_de,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_fmem_csn,
  output logic                  o_fmem_wen,
  output logic [ADDR_WIDTH-1:0] o_fmem_addr,
  output logic [MEM_WIDTH-1:0]  o_fmem_din,
  output logic                  o_frame_done,
  output logic [1:0]            o_err,
  output logic                  o_busy
);

  localparam int PIX_W  = $clog2(HRES + 1);
  localparam int LINE_W = $clog2(VRES + 1);
  // One extra bit so the word counter can hold ADDR_DEPTH ("memory full").
  localparam int WCNT_W = ADDR_WIDTH + 1;

  localparam logic [PIX_W-1:0]  PIX_MAX   = {PIX_W{1'b1}};
  localparam logic [PIX_W-1:0]  PIX_LINE  = PIX_W'(HRES);
  localparam logic [LINE_W-1:0] LINE_ALL  = LINE_W'(VRES);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(VRES - 1);
  localparam logic [WCNT_W-1:0] WORD_FULL = WCNT_W'(ADDR_DEPTH);

  cap_state_t            r_state;
  cap_state_t            w_stateNext;
  logic                  r_vsync;
  logic                  r_de;
  logic [PIX_W-1:0]      r_pixCnt;
  logic [LINE_W-1:0]     r_lineCnt;
  logic [LINE_W-1:0]     w_lineCntInc;
  logic [LINE_W-1:0]     w_lineCntNext;
  logic [WCNT_W-1:0]     r_wordCnt;
  logic                  r_csn;
  logic                  r_wen;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [MEM_WIDTH-1:0]  r_din;
  logic [MEM_WIDTH-1:0]  w_word;
  logic [1:0]            r_err;
  logic [1:0]            w_errHit;
  logic [1:0]            w_errFrame;
  logic                  w_vsRise;
  logic                  w_capture;
  logic                  w_lineEnd;
  logic                  w_lastLine;
  logic                  w_pixValid;
  logic                  w_flush;
  logic                  w_wordValid;
  logic                  w_overflow;
  logic                  w_writeDo;
  logic                  w_start;
  logic                  w_doneNext;
  logic                  w_unused;

  // hsync carries nothing the capture needs (de delimits lines); it stays on
  // the port so the block attaches to the sync generator bus unchanged.
  assign w_unused = i_hsync;

  // Edge detection on vsync and de.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync <= 1'b0;
      r_de    <= 1'b0;
    end else begin
      r_vsync <= i_vsync;
      r_de    <= i_de;
    end
  end

  assign w_vsRise  = i_vsync & ~r_vsync;
  assign w_capture = (r_state == CAP_CAPTURE);

  // A vsync rise during an active pixel closes that line before the frame
  // restarts; the pixel on the vsync cycle itself belongs to neither frame.
  assign w_lineEnd  = w_capture & ((r_de & ~i_de) | (w_vsRise & i_de));
  assign w_pixValid = w_capture & i_de & ~w_vsRise;
  assign w_flush    = w_lineEnd | w_vsRise;

  pixel_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .i_clk        (i_clk),
    .rst_n        (rst_n),
    .i_valid      (w_pixValid),
    .i_flush      (w_flush),
    .i_data       (i_data),
    .o_word       (w_word),
    .o_word_valid (w_wordValid)
  );

  // A completed word with no address left is dropped instead of wrapping.
  assign w_overflow = w_wordValid & (r_wordCnt == WORD_FULL);
  assign w_writeDo  = w_wordValid & ~w_overflow;

  assign w_lineCntInc  = (r_lineCnt == LINE_ALL) ? r_lineCnt : r_lineCnt + 1'b1;
  assign w_lineCntNext = w_lineEnd ? w_lineCntInc : r_lineCnt;
  assign w_lastLine    = w_lineEnd & (r_lineCnt == LINE_LAST);

  // Errors raised this cycle. A vsync arriving before the frame reached its
  // full line count is a line-count error, as is running out of addresses.
  always_comb begin
    w_errHit               = 2'b00;
    w_errHit[ERR_LINE_LEN] = w_lineEnd && (r_pixCnt != PIX_LINE);
    w_errHit[ERR_LINE_CNT] = w_overflow ||
                             (w_capture && w_vsRise && (w_lineCntNext != LINE_ALL));
  end

  assign w_errFrame = r_err | w_errHit;

  // State register.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CAP_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state. The frame ends at the close of line VRES-1, which is the
  // cycle after its final write, so done lines up with that strobe's
  // release. A vsync in CAPTURE aborts the frame and, with capture still
  // enabled, starts the next one straight away.
  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_doneNext  = 1'b0;
    case (r_state)
      CAP_IDLE: begin
        if (w_vsRise && i_cap_en) begin
          w_stateNext = CAP_CAPTURE;
          w_start     = 1'b1;
        end
      end
      CAP_CAPTURE: begin
        w_doneNext = w_lastLine && (w_errFrame == 2'b00);
        if (w_vsRise) begin
          if (i_cap_en) begin
            w_stateNext = CAP_CAPTURE;
            w_start     = 1'b1;
          end else begin
            w_stateNext = CAP_IDLE;
          end
        end else if (w_lastLine) begin
          w_stateNext = CAP_IDLE;
        end
      end
      default: begin
        w_stateNext = CAP_IDLE;
      end
    endcase
  end

  // Counters, error flags and the registered memory port. On a restart out
  // of CAPTURE the error vector reports the frame that was cut short, so an
  // early vsync stays visible; a start from IDLE begins with a clean slate.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixCnt  <= '0;
      r_lineCnt <= '0;
      r_wordCnt <= '0;
      r_addr    <= '0;
      r_din     <= '0;
      r_csn     <= 1'b1;
      r_wen     <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 2'b00;
    end else begin
      r_csn  <= ~w_writeDo;
      r_wen  <= ~w_writeDo;
      r_done <= w_doneNext;
      if (w_start) begin
        r_pixCnt  <= '0;
        r_lineCnt <= '0;
        r_wordCnt <= '0;
        r_addr    <= '0;
        r_err     <= w_capture ? w_errFrame : 2'b00;
      end else begin
        if (w_lineEnd) begin
          r_pixCnt <= '0;
        end else if (w_pixValid && (r_pixCnt != PIX_MAX)) begin
          r_pixCnt <= r_pixCnt + 1'b1;
        end
        r_lineCnt <= w_lineCntNext;
        if (w_writeDo) begin
          r_addr    <= r_wordCnt[ADDR_WIDTH-1:0];
          r_din     <= w_word;
          r_wordCnt <= r_wordCnt + 1'b1;
        end
        if (w_capture) begin
          r_err <= w_errFrame;
        end
      end
    end
  end

  assign o_fmem_csn   = r_csn;
  assign o_fmem_wen   = r_wen;
  assign o_fmem_addr  = r_addr;
  assign o_fmem_din   = r_din;
  assign o_frame_done = r_done;
  assign o_err        = r_err;
  assign o_busy       = w_capture;

endmodule

// File: tb/tb_disp_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_disp_frame_capture
// Drives a reduced-size raster (16x6) through disp_frame_capture. A table of
// frame scenarios is played back in order; for each captured pixel the bench
// packs its own expected word and queues {addr, din}, and a monitor pops the
// queue on every write strobe. Per-frame totals are checked after each frame.
// ---------------------------------------------------------------------------
module tb_disp_frame_capture;

  localparam int HRES  = 16;
  localparam int VRES  = 6;
  localparam int DW    = 8;
  localparam int MW    = DW * 4;
  localparam int DEPTH = HRES * VRES / 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int VBP   = 3;
  localparam int VFP   = 5;
  localparam int HSW   = 2;
  localparam int HBP   = 4;
  localparam int HFP   = 5;
  localparam int NVEC  = 10;

  typedef struct {
    bit         capEn;
    int         nLines;
    int         shortLine;
    int         shortLen;
    int         resetLine;
    int         expWrites;
    int         expDones;
    logic [1:0] expErr;
    bit         expBusy;
  } frameVec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [MW-1:0] din;
  } sbEntry_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          capEn = 1'b0;
  logic          vsync = 1'b0;
  logic          hsync = 1'b0;
  logic          de    = 1'b0;
  logic [DW-1:0] data  = '0;

  logic          fmemCsn;
  logic          fmemWen;
  logic [AW-1:0] fmemAddr;
  logic [MW-1:0] fmemDin;
  logic          frameDone;
  logic [1:0]    err;
  logic          busy;

  frameVec_t vecs[NVEC];
  sbEntry_t  sbQ[$];
  int        nChecks    = 0;
  int        nPass      = 0;
  int        writesSeen = 0;
  int        donesSeen  = 0;
  logic      prevCsn    = 1'b1;
  bit        modelCap   = 1'b0;
  int        modelAddr  = 0;
  int        modelSlot  = 0;
  logic [MW-1:0] modelWord = '0;

  disp_frame_capture #(
    .HRES       (HRES),
    .VRES       (VRES),
    .DATA_WIDTH (DW),
    .MEM_WIDTH  (MW),
    .ADDR_DEPTH (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk        (clk),
    .rst_n        (rst_n),
    .i_cap_en     (capEn),
    .i_vsync      (vsync),
    .i_hsync      (hsync),
    .i_de         (de),
    .i_data       (data),
    .o_fmem_csn   (fmemCsn),
    .o_fmem_wen   (fmemWen),
    .o_fmem_addr  (fmemAddr),
    .o_fmem_din   (fmemDin),
    .o_frame_done (frameDone),
    .o_err        (err),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    nChecks++;
    if (act === expv) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Write-strobe and done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!fmemCsn) begin
        sbEntry_t e;
        writesSeen++;
        check("wenWithCsn", 64'(fmemWen), 64'(0));
        check("sbPending", 64'(sbQ.size() > 0), 64'(1));
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          check("writeAddr", 64'(fmemAddr), 64'(e.addr));
          check("writeDin", 64'(fmemDin), 64'(e.din));
        end
      end
      if (frameDone) begin
        donesSeen++;
        check("doneAlign", 64'(prevCsn), 64'(0));
      end
      prevCsn = fmemCsn;
    end
  end

  task automatic driveCycle(input logic vs, input logic hs, input logic d,
                            input logic [DW-1:0] px);
    @(posedge clk);
    #1;
    vsync = vs;
    hsync = hs;
    de    = d;
    data  = px;
  endtask

  task automatic blankLine();
    for (int i = 0; i < HSW; i++) driveCycle(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < HBP + HRES + HFP; i++) driveCycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic sendLine(input int frame, input int ln, input int len, input int resetLine);
    logic [DW-1:0] px;
    for (int i = 0; i < HSW; i++) driveCycle(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < HBP; i++) driveCycle(1'b0, 1'b0, 1'b0, '0);
    modelSlot = 0;
    for (int p = 0; p < len; p++) begin
      px = DW'((ln * HRES + p + 37 * frame) % 256);
      driveCycle(1'b0, 1'b0, 1'b1, px);
      if (ln == resetLine && p == 6) begin
        rst_n      = 1'b0;
        modelCap   = 1'b0;
        writesSeen = 0;
        sbQ.delete();
        #1;
        check("rstMidCsn", 64'(fmemCsn), 64'(1));
        check("rstMidWen", 64'(fmemWen), 64'(1));
        check("rstMidAddr", 64'(fmemAddr), 64'(0));
        check("rstMidBusy", 64'(busy), 64'(0));
      end
      if (ln == resetLine && p == 9) rst_n = 1'b1;
      if (modelCap) begin
        modelWord[modelSlot*DW +: DW] = px;
        modelSlot++;
        if (modelSlot == 4) begin
          if (modelAddr < DEPTH) sbQ.push_back('{addr: AW'(modelAddr), din: modelWord});
          modelAddr++;
          modelSlot = 0;
        end
      end
    end
    for (int i = 0; i < HFP; i++) driveCycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Plays one frame scenario from the table.
  task automatic applyStimulus(input int idx);
    frameVec_t fv;
    fv         = vecs[idx];
    capEn      = fv.capEn;
    writesSeen = 0;
    donesSeen  = 0;
    modelCap   = fv.capEn;
    modelAddr  = 0;
    driveCycle(1'b1, 1'b0, 1'b0, '0);
    driveCycle(1'b1, 1'b0, 1'b0, '0);
    for (int l = 0; l < VBP; l++) blankLine();
    for (int l = 0; l < fv.nLines; l++) begin
      sendLine(idx, l, (l == fv.shortLine) ? fv.shortLen : HRES, fv.resetLine);
    end
    for (int l = 0; l < VFP; l++) blankLine();
  endtask

  task automatic checkOutput(input int idx);
    frameVec_t fv;
    fv = vecs[idx];
    @(negedge clk);
    $display("[TB] frame %0d: writes=%0d dones=%0d err=%b busy=%b",
             idx, writesSeen, donesSeen, err, busy);
    check($sformatf("f%0d_writes", idx), 64'(writesSeen), 64'(fv.expWrites));
    check($sformatf("f%0d_dones", idx), 64'(donesSeen), 64'(fv.expDones));
    check($sformatf("f%0d_err", idx), 64'(err), 64'(fv.expErr));
    check($sformatf("f%0d_busy", idx), 64'(busy), 64'(fv.expBusy));
    check($sformatf("f%0d_sbDrain", idx), 64'(sbQ.size()), 64'(0));
  endtask

  initial begin
    //           capEn nLines shortLn shortLen rstLn expWrites  dones err    busy
    vecs[0] = '{1'b1, VRES,  -1,     HRES,    -1,   DEPTH,     1,    2'b00, 1'b0}; // clean
    vecs[1] = '{1'b1, VRES,  2,      14,      -1,   DEPTH - 1, 0,    2'b01, 1'b0}; // short line
    vecs[2] = '{1'b0, VRES,  -1,     HRES,    -1,   0,         0,    2'b01, 1'b0}; // cap_en=0
    vecs[3] = '{1'b1, VRES,  -1,     HRES,    -1,   DEPTH,     1,    2'b00, 1'b0}; // clean
    vecs[4] = '{1'b1, 3,     -1,     HRES,    -1,   12,        0,    2'b00, 1'b1}; // cut short
    vecs[5] = '{1'b1, VRES,  -1,     HRES,    -1,   DEPTH,     0,    2'b10, 1'b0}; // after early vsync
    vecs[6] = '{1'b1, VRES,  -1,     HRES,    3,    0,         0,    2'b00, 1'b0}; // reset mid-frame
    vecs[7] = '{1'b1, VRES,  -1,     HRES,    -1,   DEPTH,     1,    2'b00, 1'b0}; // back-to-back
    vecs[8] = '{1'b1, VRES,  -1,     HRES,    -1,   DEPTH,     1,    2'b00, 1'b0};
    vecs[9] = '{1'b1, VRES,  -1,     HRES,    -1,   DEPTH,     1,    2'b00, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstCsn", 64'(fmemCsn), 64'(1));
    check("rstWen", 64'(fmemWen), 64'(1));
    check("rstAddr", 64'(fmemAddr), 64'(0));
    check("rstDin", 64'(fmemDin), 64'(0));
    check("rstDone", 64'(frameDone), 64'(0));
    check("rstErr", 64'(err), 64'(0));
    check("rstBusy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i);
      checkOutput(i);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
